// File: rtl/atp_gateway_arbiter_pkg.sv
// Shared types and sizing helpers for the ATP payment-gateway arbiter
// and its round-robin picker.
package atp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } atp_state_e;

    localparam int AMT_W_DEF = 16;

    function automatic int wd_width(input int timeout_cyc);
        return $clog2(timeout_cyc + 1);
    endfunction

    // Index width for an owner number; never below one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/atp_gateway_arbiter_if.sv
// Kiosk-side and gateway-side bundle of the arbiter; master is the arbiter,
// slave is the kiosks plus gateway environment.
interface atp_gateway_arbiter_if #(
    parameter int NUM_KIOSKS = 4,
    parameter int AMT_W      = 16
);
    logic [NUM_KIOSKS-1:0]       kioskReq;
    logic [NUM_KIOSKS*AMT_W-1:0] kioskAmount;
    logic [NUM_KIOSKS-1:0]       kioskGrant;
    logic [NUM_KIOSKS-1:0]       kioskDone;
    logic                        kioskPaid;
    logic                        gwReq;
    logic [AMT_W-1:0]            gwAmount;
    logic                        gwAck;
    logic                        gwPaid;
    logic                        timeoutFlag;
    logic                        busy;

    modport master (
        input  kioskReq, kioskAmount, gwAck, gwPaid,
        output kioskGrant, kioskDone, kioskPaid, gwReq, gwAmount, timeoutFlag, busy
    );

    modport slave (
        output kioskReq, kioskAmount, gwAck, gwPaid,
        input  kioskGrant, kioskDone, kioskPaid, gwReq, gwAmount, timeoutFlag, busy
    );

endinterface

// File: rtl/atp_gateway_arbiter_rr_picker.sv
// Combinational round-robin picker: searches from last_i+1 (mod NUM) and
// returns the first requester as one-hot, index and valid.
module atp_rr_picker #(
    parameter int NUM  = 4,
    parameter int IDXW = 2
) (
    input  logic [NUM-1:0]  req_i,
    input  logic [IDXW-1:0] last_i,
    output logic [NUM-1:0]  grant_o,
    output logic [IDXW-1:0] idx_o,
    output logic            valid_o
);

    logic [IDXW:0] sum_s;
    logic [IDXW:0] cand_s;
    logic          hit_s;

    // The just-served owner is visited last, so it has lowest priority.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        sum_s   = '0;
        cand_s  = '0;
        hit_s   = 1'b0;
        for (int i = 1; i <= NUM; i++) begin
            sum_s = {1'b0, last_i} + (IDXW+1)'(i);
            if (sum_s >= (IDXW+1)'(NUM)) begin
                cand_s = sum_s - (IDXW+1)'(NUM);
            end else begin
                cand_s = sum_s;
            end
            hit_s = req_i[cand_s[IDXW-1:0]] && !valid_o;
            grant_o[cand_s[IDXW-1:0]] = hit_s;
            idx_o   = hit_s ? cand_s[IDXW-1:0] : idx_o;
            valid_o = valid_o | hit_s;
        end
    end

endmodule

// File: rtl/atp_gateway_arbiter.sv
// Round-robin sharing of one payment-gateway channel between kiosk controllers.
// Optional watchdog abort of unanswered gateway requests: ATP_GW_TIMEOUT_EN.
module atp_gateway_arbiter
    import atp_pkg::*;
#(
    parameter int NUM_KIOSKS  = 4,
    parameter int AMT_W       = AMT_W_DEF,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    atp_gateway_arbiter_if.master bus
);

    localparam int IDXW = idx_width(NUM_KIOSKS);

    if (NUM_KIOSKS < 2 || NUM_KIOSKS > 16 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("atp_gateway_arbiter: parameter out of range");
    end

    atp_state_e            state_q, state_d;
    logic [NUM_KIOSKS-1:0] grant_q, grant_d;
    logic [NUM_KIOSKS-1:0] done_q, done_d;
    logic                  paid_q, paid_d;
    logic                  gw_req_q, gw_req_d;
    logic [AMT_W-1:0]      gw_amount_q, gw_amount_d;
    logic                  tmo_q, tmo_d;
    logic                  busy_q, busy_d;
    logic [IDXW-1:0]       last_q, last_d;

    logic [NUM_KIOSKS-1:0] pick_grant_s;
    logic [IDXW-1:0]       pick_idx_s;
    logic                  pick_valid_s;
    logic [AMT_W-1:0]      pick_amount_s;
    logic                  wd_expire_s;

    atp_rr_picker #(
        .NUM  (NUM_KIOSKS),
        .IDXW (IDXW)
    ) u_picker (
        .req_i   (bus.kioskReq),
        .last_i  (last_q),
        .grant_o (pick_grant_s),
        .idx_o   (pick_idx_s),
        .valid_o (pick_valid_s)
    );

    // One-hot mux of the winner's amount.
    always_comb begin
        pick_amount_s = '0;
        for (int i = 0; i < NUM_KIOSKS; i++) begin
            pick_amount_s = pick_amount_s |
                ({AMT_W{pick_grant_s[i]}} & bus.kioskAmount[i*AMT_W +: AMT_W]);
        end
    end

`ifdef ATP_GW_TIMEOUT_EN
    localparam int WDW = wd_width(TIMEOUT_CYC);
    logic [WDW-1:0] wd_q, wd_d;

    // Counts WAIT cycles without an ack; expiry lands on the TIMEOUT_CYC-th one.
    always_comb begin
        wd_d        = wd_q;
        wd_expire_s = 1'b0;
        if (state_q == WAIT && !bus.gwAck) begin
            wd_d        = wd_q + WDW'(1);
            wd_expire_s = (wd_d == WDW'(TIMEOUT_CYC));
        end else if (state_q == IDLE) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign wd_expire_s = 1'b0;
`endif

    // Next-state and next-output computation; gwAck wins over watchdog expiry.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        done_d      = '0;
        paid_d      = 1'b0;
        gw_req_d    = gw_req_q;
        gw_amount_d = gw_amount_q;
        tmo_d       = 1'b0;
        last_d      = last_q;
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    state_d     = WAIT;
                    grant_d     = pick_grant_s;
                    gw_amount_d = pick_amount_s;
                    gw_req_d    = 1'b1;
                    last_d      = pick_idx_s;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (bus.gwAck) begin
                    state_d  = DONE;
                    gw_req_d = 1'b0;
                    done_d   = grant_q;
                    paid_d   = bus.gwPaid;
                end else if (wd_expire_s) begin
                    state_d  = DONE;
                    gw_req_d = 1'b0;
                    done_d   = grant_q;
                    paid_d   = 1'b0;
                    tmo_d    = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: begin
                state_d  = IDLE;
                grant_d  = '0;
                gw_req_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // FSM state and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            paid_q      <= 1'b0;
            gw_req_q    <= 1'b0;
            gw_amount_q <= '0;
            tmo_q       <= 1'b0;
            busy_q      <= 1'b0;
            last_q      <= IDXW'(NUM_KIOSKS - 1);
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            paid_q      <= paid_d;
            gw_req_q    <= gw_req_d;
            gw_amount_q <= gw_amount_d;
            tmo_q       <= tmo_d;
            busy_q      <= busy_d;
            last_q      <= last_d;
        end
    end

    assign bus.kioskGrant  = grant_q;
    assign bus.kioskDone   = done_q;
    assign bus.kioskPaid   = paid_q;
    assign bus.gwReq       = gw_req_q;
    assign bus.gwAmount    = gw_amount_q;
    assign bus.timeoutFlag = tmo_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_atp_gateway_arbiter.sv
// Directed self-checking bench for atp_gateway_arbiter (4 kiosks, 16-bit amounts);
// watchdog scenarios run when ATP_GW_TIMEOUT_EN is defined.
module tb_atp_gateway_arbiter;

    localparam int NK = 4;
    localparam int AW = 16;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    atp_gateway_arbiter_if #(.NUM_KIOSKS(NK), .AMT_W(AW)) bus_if ();

    atp_gateway_arbiter #(
        .NUM_KIOSKS  (NK),
        .AMT_W       (AW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_amt(input int k, input logic [AW-1:0] a);
        bus_if.kioskAmount[k*AW +: AW] = a;
    endtask

    // Grant on next edge, single-cycle ack, done pulse, back to IDLE.
    task automatic serve(input string tag, input logic [NK-1:0] g, input logic [AW-1:0] amt,
                         input logic paid, input logic [NK-1:0] drop);
        step();
        chk({tag, ".grant"}, 32'(bus_if.kioskGrant), 32'(g));
        chk({tag, ".gwReq"}, 32'(bus_if.gwReq), 32'd1);
        chk({tag, ".gwAmount"}, 32'(bus_if.gwAmount), 32'(amt));
        chk({tag, ".busy"}, 32'(bus_if.busy), 32'd1);
        bus_if.gwAck  = 1'b1;
        bus_if.gwPaid = paid;
        step();
        chk({tag, ".done"}, 32'(bus_if.kioskDone), 32'(g));
        chk({tag, ".paid"}, 32'(bus_if.kioskPaid), 32'(paid));
        chk({tag, ".gwReqDrop"}, 32'(bus_if.gwReq), 32'd0);
        chk({tag, ".tmo"}, 32'(bus_if.timeoutFlag), 32'd0);
        bus_if.gwAck    = 1'b0;
        bus_if.gwPaid   = 1'b0;
        bus_if.kioskReq = bus_if.kioskReq & ~drop;
        step();
        chk({tag, ".doneEnd"}, 32'(bus_if.kioskDone), 32'd0);
        chk({tag, ".grantEnd"}, 32'(bus_if.kioskGrant), 32'd0);
        chk({tag, ".idle"}, 32'(bus_if.busy), 32'd0);
    endtask

    initial begin
        reset              = 1'b1;
        bus_if.kioskReq    = '0;
        bus_if.kioskAmount = '0;
        bus_if.gwAck       = 1'b0;
        bus_if.gwPaid      = 1'b0;
        step();
        step();
        chk("rst.grant", 32'(bus_if.kioskGrant), 32'd0);
        chk("rst.done", 32'(bus_if.kioskDone), 32'd0);
        chk("rst.paid", 32'(bus_if.kioskPaid), 32'd0);
        chk("rst.gwReq", 32'(bus_if.gwReq), 32'd0);
        chk("rst.gwAmount", 32'(bus_if.gwAmount), 32'd0);
        chk("rst.tmo", 32'(bus_if.timeoutFlag), 32'd0);
        chk("rst.busy", 32'(bus_if.busy), 32'd0);
        reset = 1'b0;

        // All four together: order 0,1,2,3, then kiosk 0 again.
        set_amt(0, 16'd100);
        set_amt(1, 16'd200);
        set_amt(2, 16'd300);
        set_amt(3, 16'd400);
        bus_if.kioskReq = 4'b1111;
        serve("rr0", 4'b0001, 16'd100, 1'b1, 4'b0001);
        serve("rr1", 4'b0010, 16'd200, 1'b1, 4'b0010);
        serve("rr2", 4'b0100, 16'd300, 1'b1, 4'b0100);
        serve("rr3", 4'b1000, 16'd400, 1'b1, 4'b1000);
        bus_if.kioskReq = 4'b0001;
        serve("rr0b", 4'b0001, 16'd100, 1'b1, 4'b0001);

        // Single kiosk 0, amount change and request withdrawal after grant, ack in cycle 3.
        set_amt(0, 16'd450);
        bus_if.kioskReq = 4'b0001;
        step();
        chk("k0.grant", 32'(bus_if.kioskGrant), 32'd1);
        chk("k0.gwReq", 32'(bus_if.gwReq), 32'd1);
        chk("k0.gwAmount", 32'(bus_if.gwAmount), 32'd450);
        set_amt(0, 16'd999);
        step();
        chk("k0.amtHeld", 32'(bus_if.gwAmount), 32'd450);
        bus_if.kioskReq = 4'b0000;
        step();
        chk("k0.grantHeld", 32'(bus_if.kioskGrant), 32'd1);
        chk("k0.gwReqHeld", 32'(bus_if.gwReq), 32'd1);
        bus_if.gwAck  = 1'b1;
        bus_if.gwPaid = 1'b1;
        step();
        chk("k0.done", 32'(bus_if.kioskDone), 32'd1);
        chk("k0.paid", 32'(bus_if.kioskPaid), 32'd1);
        bus_if.gwAck  = 1'b0;
        bus_if.gwPaid = 1'b0;
        step();
        chk("k0.doneOnce", 32'(bus_if.kioskDone), 32'd0);
        chk("k0.paidLow", 32'(bus_if.kioskPaid), 32'd0);
        chk("k0.busyLow", 32'(bus_if.busy), 32'd0);

        // Kiosk 2 keeps requesting after done; kiosk 3 must win next.
        bus_if.kioskReq = 4'b0100;
        serve("hold2", 4'b0100, 16'd300, 1'b1, 4'b0000);
        bus_if.kioskReq = 4'b1100;
        serve("next3", 4'b1000, 16'd400, 1'b0, 4'b1100);

        // Reset in WAIT, then search restarts at kiosk 0.
        set_amt(0, 16'h0ABC);
        bus_if.kioskReq = 4'b0001;
        step();
        chk("rw.grant", 32'(bus_if.kioskGrant), 32'd1);
        reset = 1'b1;
        step();
        chk("rw.gwReq", 32'(bus_if.gwReq), 32'd0);
        chk("rw.grant0", 32'(bus_if.kioskGrant), 32'd0);
        chk("rw.busy", 32'(bus_if.busy), 32'd0);
        chk("rw.gwAmount", 32'(bus_if.gwAmount), 32'd0);
        reset = 1'b0;
        set_amt(1, 16'hFFFF);
        bus_if.kioskReq = 4'b0011;
        serve("rw.after", 4'b0001, 16'h0ABC, 1'b1, 4'b0001);

        // Declined payment for kiosk 1 at maximum amount.
        serve("decl", 4'b0010, 16'hFFFF, 1'b0, 4'b0010);

        // Stale ack in IDLE is ignored.
        bus_if.gwAck  = 1'b1;
        bus_if.gwPaid = 1'b1;
        step();
        chk("stale.done", 32'(bus_if.kioskDone), 32'd0);
        chk("stale.busy", 32'(bus_if.busy), 32'd0);
        chk("stale.gwReq", 32'(bus_if.gwReq), 32'd0);
        bus_if.gwAck  = 1'b0;
        bus_if.gwPaid = 1'b0;

`ifdef ATP_GW_TIMEOUT_EN
        // Silent gateway: done after TO WAIT cycles, unpaid, timeoutFlag.
        set_amt(2, 16'h0777);
        bus_if.kioskReq = 4'b0100;
        step();
        chk("to.grant", 32'(bus_if.kioskGrant), 32'b0100);
        for (int c = 2; c <= TO; c++) begin
            step();
            chk("to.waiting", 32'(bus_if.gwReq), 32'd1);
        end
        step();
        chk("to.done", 32'(bus_if.kioskDone), 32'b0100);
        chk("to.paid", 32'(bus_if.kioskPaid), 32'd0);
        chk("to.flag", 32'(bus_if.timeoutFlag), 32'd1);
        chk("to.gwReq", 32'(bus_if.gwReq), 32'd0);
        bus_if.kioskReq = 4'b0000;
        step();
        chk("to.flagOnce", 32'(bus_if.timeoutFlag), 32'd0);
        bus_if.gwAck  = 1'b1;
        bus_if.gwPaid = 1'b1;
        step();
        chk("to.lateAck", 32'(bus_if.kioskDone), 32'd0);
        chk("to.lateBusy", 32'(bus_if.busy), 32'd0);
        bus_if.gwAck  = 1'b0;
        bus_if.gwPaid = 1'b0;

        // Ack in the expiry cycle wins.
        set_amt(3, 16'd55);
        bus_if.kioskReq = 4'b1000;
        step();
        chk("tw.grant", 32'(bus_if.kioskGrant), 32'b1000);
        for (int c = 2; c <= TO; c++) begin
            step();
        end
        chk("tw.stillWait", 32'(bus_if.gwReq), 32'd1);
        bus_if.gwAck  = 1'b1;
        bus_if.gwPaid = 1'b1;
        step();
        chk("tw.done", 32'(bus_if.kioskDone), 32'b1000);
        chk("tw.paid", 32'(bus_if.kioskPaid), 32'd1);
        chk("tw.flag", 32'(bus_if.timeoutFlag), 32'd0);
        bus_if.gwAck    = 1'b0;
        bus_if.gwPaid   = 1'b0;
        bus_if.kioskReq = 4'b0000;
        step();
`else
        // Without the watchdog, WAIT holds for as long as the gateway is silent.
        set_amt(2, 16'h0777);
        bus_if.kioskReq = 4'b0100;
        step();
        chk("nowd.grant", 32'(bus_if.kioskGrant), 32'b0100);
        for (int c = 0; c < 40; c++) begin
            step();
        end
        chk("nowd.gwReq", 32'(bus_if.gwReq), 32'd1);
        chk("nowd.done", 32'(bus_if.kioskDone), 32'd0);
        chk("nowd.flag", 32'(bus_if.timeoutFlag), 32'd0);
        bus_if.gwAck  = 1'b1;
        bus_if.gwPaid = 1'b1;
        step();
        chk("nowd.doneAck", 32'(bus_if.kioskDone), 32'b0100);
        bus_if.gwAck    = 1'b0;
        bus_if.gwPaid   = 1'b0;
        bus_if.kioskReq = 4'b0000;
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
